shift_result_stage: RTL and testbench
=====================================

// Module: shift_result_stage
// PURPOSE
//  Pipeline stage directly downstream of the 16-bit shifter. It registers each
//  shifter result and carry-out into a small in-order FIFO with valid/ready on
//  both sides. It maintains the architectural N/Z/C flag register, which is
//  updated when an entry retires to writeback with its set_flags bit high.
// PARAMETERS
//  WIDTH  16  data width; must match the shifter out width
//  DEPTH  2   FIFO entries; power of 2, >= 2
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      synchronous, active-high
//  in_valid     in   1      upstream holds a valid shifter result this cycle
//  in_ready     out  1      stage can accept (FIFO not full)
//  in_data      in   WIDTH  shifter out
//  in_c         in   1      shifter carry-out c
//  in_amt_zero  in   1      shift amount was 0: carry-out not meaningful
//  in_set_flags in   1      this op updates flags on retire
//  out_valid    out  1      head entry valid
//  out_ready    in   1      writeback consumes head this cycle
//  out_data     out  WIDTH  head entry data
//  flag_n       out  1      N flag: data[WIDTH-1] of last flag-setting retire
//  flag_z       out  1      Z flag: data == 0
//  flag_c       out  1      C flag
//  retired      out  8      count of retired entries, wraps 255->0
// BEHAVIOUR
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH). It is combinational from state only, never
//    from in_valid or out_ready.
//  - out_valid = (count != 0). out_data is the head entry, driven from a register.
//  - Latency: an entry pushed in cycle T is visible at out_valid in T+1, at the
//    earliest. No combinational path from in_* to out_*.
//  - Order is strictly FIFO. rd_ptr and wr_ptr wrap modulo DEPTH.
//  - count update:
//      push only  -> +1
//      pop only   -> -1
//      both       -> unchanged
//      full       -> push is impossible, so a pop alone decrements
//  - Push and pop together at count==1: the head retires, and the new entry
//    becomes the head in the next cycle. out_valid stays 1.
//  - Empty: a pop cannot occur. out_data holds its last value (don't-care).
//  - Upstream must hold in_* stable while in_valid & !in_ready. A drop of
//    in_valid without a handshake is legal and pushes nothing.
//  - Flags update only on a pop whose entry has set_flags=1:
//      N <= data[WIDTH-1]
//      Z <= (data == 0)
//      C <= amt_zero ? C (unchanged) : c
//    A pop with set_flags=0 leaves all flags unchanged. No-pop cycles leave
//    them unchanged.
//  - retired increments by 1 on every pop, regardless of set_flags.
//  - Reset, including mid-operation:
//      count, rd_ptr, wr_ptr, flag_n/z/c and retired all <= 0
//      out_valid = 0 and in_ready = 1 from the first cycle after reset
//      in-flight entries are discarded
//      in_valid during reset is ignored
//  - Arithmetic is unsigned. count is $clog2(DEPTH)+1 bits. There is no
//    overflow or underflow by construction.
// TESTING
//  1 Reset then idle: out_valid=0, in_ready=1, flags=000, retired=0.
//  2 Push data=16'h8001, c=1, amt_zero=0, set_flags=1, with out_ready=1:
//    out_valid rises in T+1 with out_data=8001. After the pop, N=1, Z=0, C=1,
//    retired=1.
//  3 Backpressure: out_ready=0, push 3 values (A, B, C). in_ready=0 after 2 are
//    accepted and C is held. Then out_ready=1 pops A, B, C in order with no
//    loss or duplicates.
//  4 Carry preserve: first retire data=0, c=1, set=1 -> Z=1, C=1. Next retire
//    data=5, c=0, amt_zero=1, set=1 -> Z=0, N=0, C stays 1.
//  5 set_flags=0: retire 16'hFFFF with c=0. Flags unchanged, retired increments.
//  6 Reset mid-run: assert reset with count=2. Next cycle out_valid=0,
//    in_ready=1, flags=0. A following push of 16'h1234 emerges alone.

Source files
------------

// File: rtl/shift_result_stage_if.sv
// Handshake bundle around the shifter result stage: upstream push side and writeback pop side.
// master drives results in and consumes the head; slave is the stage itself.
interface shift_result_stage_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_c;
    logic             in_amt_zero;
    logic             in_set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_c, in_amt_zero, in_set_flags, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_c, in_amt_zero, in_set_flags, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_result_stage.sv
// Registers shifter results into an in-order FIFO and maintains N/Z/C on flag-setting retires.
// Latency: push in T is visible at T+1; in_ready/out_valid come from state only, so full stalls upstream.
module shift_result_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    shift_result_stage_if.slave    bus,
    output logic                   flag_n,
    output logic                   flag_z,
    output logic                   flag_c,
    output logic [7:0]             retired
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             c;
        logic             amt_zero;
        logic             set_flags;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    entry_t            wr_entry;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    assign bus.in_ready  = (count != FULL_CNT);
    assign bus.out_valid = (count != '0);

    assign push = bus.in_valid  & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    assign wr_entry = '{data:      bus.in_data,
                        c:         bus.in_c,
                        amt_zero:  bus.in_amt_zero,
                        set_flags: bus.in_set_flags};

    assign head         = mem[rd_ptr];
    assign bus.out_data = head.data;

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A zero shift amount leaves carry meaningless, so C keeps its old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_n  <= 1'b0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            retired <= 8'd0;
        end else if (pop) begin
            retired <= retired + 8'd1;
            if (head.set_flags) begin
                flag_n <= head.data[WIDTH-1];
                flag_z <= (head.data == '0);
                if (!head.amt_zero) begin
                    flag_c <= head.c;
                end
            end
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (reset) count <= FULL_CNT);
    a_no_push_full: assert property (@(posedge clk) disable iff (reset) (count == FULL_CNT) |-> !push);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) (count == '0) |-> !pop);
endmodule

// File: tb/tb_shift_result_stage.sv
module tb_shift_result_stage;
    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic [7:0] retired;

    shift_result_stage_if #(.WIDTH(WIDTH)) bus ();

    shift_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .flag_n  (flag_n),
        .flag_z  (flag_z),
        .flag_c  (flag_c),
        .retired (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        c;
        logic        amt_zero;
        logic        set_flags;
    } ent_t;

    typedef struct {
        logic [15:0] data;
        logic        c;
        logic        az;
        logic        sf;
        logic        en;
        logic        ez;
        logic        ec;
    } vec_t;

    ent_t       sb[$];
    ent_t       mon_e;
    logic       m_n, m_z, m_c;
    logic [7:0] m_ret;
    bit         mon_en = 1'b0;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: handshakes seen away from the edge are applied to the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
            chk("in_ready", 32'(bus.in_ready), 32'(sb.size() != DEPTH));
            chk("flag_n", 32'(flag_n), 32'(m_n));
            chk("flag_z", 32'(flag_z), 32'(m_z));
            chk("flag_c", 32'(flag_c), 32'(m_c));
            chk("retired", 32'(retired), 32'(m_ret));
            if (reset) begin
                sb.delete();
                m_n = 1'b0;
                m_z = 1'b0;
                m_c = 1'b0;
                m_ret = 8'd0;
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("pop_when_model_empty", 32'(1), 32'(0));
                    end else begin
                        mon_e = sb.pop_front();
                        chk("out_data", 32'(bus.out_data), 32'(mon_e.data));
                        m_ret = m_ret + 8'd1;
                        if (mon_e.set_flags) begin
                            m_n = mon_e.data[15];
                            m_z = (mon_e.data == 16'h0);
                            if (!mon_e.amt_zero) m_c = mon_e.c;
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    sb.push_back({bus.in_data, bus.in_c, bus.in_amt_zero, bus.in_set_flags});
                end
            end
        end
    end

    task automatic drive(input logic [15:0] d, input logic c, input logic az, input logic sf);
        bus.in_valid     = 1'b1;
        bus.in_data      = d;
        bus.in_c         = c;
        bus.in_amt_zero  = az;
        bus.in_set_flags = sf;
    endtask

    task automatic wait_accept();
        bit got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("push_timeout", 32'(got), 32'(1));
    endtask

    task automatic push_one(input logic [15:0] d, input logic c, input logic az, input logic sf);
        @(posedge clk);
        #1;
        drive(d, c, az, sf);
        wait_accept();
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus.out_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_timeout", 32'(done), 32'(1));
    endtask

    task automatic set_out_ready(input logic r);
        @(posedge clk);
        #1;
        bus.out_ready = r;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vec_t       vt[8];
        logic [7:0] ret0;
        bit         took;

        vt[0] = '{16'h8001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[1] = '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[2] = '{16'h0005, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[3] = '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[4] = '{16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5] = '{16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[6] = '{16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[7] = '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_data      = 16'h0;
        bus.in_c         = 1'b0;
        bus.in_amt_zero  = 1'b0;
        bus.in_set_flags = 1'b0;
        bus.out_ready    = 1'b0;
        m_n = 1'b0; m_z = 1'b0; m_c = 1'b0; m_ret = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        @(negedge clk);
        chk("idle_out_valid", 32'(bus.out_valid), 32'(0));
        chk("idle_in_ready", 32'(bus.in_ready), 32'(1));
        chk("idle_flags", 32'({flag_n, flag_z, flag_c}), 32'(0));
        chk("idle_retired", 32'(retired), 32'(0));

        // Table: one retire per vector, flags compared to hand-derived values.
        set_out_ready(1'b1);
        for (int i = 0; i < 8; i++) begin
            push_one(vt[i].data, vt[i].c, vt[i].az, vt[i].sf);
            chk("vec_out_valid_t1", 32'(bus.out_valid), 32'(1));
            chk("vec_out_data", 32'(bus.out_data), 32'(vt[i].data));
            wait_drain();
            chk("vec_flag_n", 32'(flag_n), 32'(vt[i].en));
            chk("vec_flag_z", 32'(flag_z), 32'(vt[i].ez));
            chk("vec_flag_c", 32'(flag_c), 32'(vt[i].ec));
            chk("vec_retired", 32'(retired), 32'(i + 1));
        end

        // Backpressure: two accepted, third held until writeback drains.
        ret0 = retired;
        set_out_ready(1'b0);
        push_one(16'hAAAA, 1'b0, 1'b0, 1'b0);
        push_one(16'hBBBB, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(16'hCCCC, 1'b1, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_full", 32'(bus.in_ready), 32'(0));
            chk("bp_head_held", 32'(bus.out_data), 32'(16'hAAAA));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_accept();
        wait_drain();
        chk("bp_retired", 32'(retired), 32'(ret0 + 8'd3));

        // Random streaming with legal hold behaviour; long enough to wrap retired.
        for (int cyc = 0; cyc < 900; cyc++) begin
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (took || !bus.in_valid) begin
                bus.in_valid     = ($urandom_range(0, 3) != 0);
                bus.in_data      = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom());
                bus.in_c         = 1'($urandom_range(0, 1));
                bus.in_amt_zero  = ($urandom_range(0, 3) == 0);
                bus.in_set_flags = 1'($urandom_range(0, 1));
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        took = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
        if (!took && bus.in_valid) wait_accept();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();

        // Reset with the FIFO full and flags set; in_valid during reset is ignored.
        push_one(16'h8000, 1'b1, 1'b0, 1'b1);
        wait_drain();
        chk("pre_reset_flags", 32'({flag_n, flag_z, flag_c}), 32'(3'b101));
        set_out_ready(1'b0);
        push_one(16'h1111, 1'b1, 1'b0, 1'b1);
        push_one(16'h2222, 1'b1, 1'b0, 1'b1);
        chk("pre_reset_full", 32'(bus.in_ready), 32'(0));
        reset = 1'b1;
        drive(16'hDEAD, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
        chk("rst_flags", 32'({flag_n, flag_z, flag_c}), 32'(0));
        chk("rst_retired", 32'(retired), 32'(0));
        set_out_ready(1'b1);
        push_one(16'h1234, 1'b0, 1'b0, 1'b1);
        chk("post_rst_head", 32'(bus.out_data), 32'(16'h1234));
        wait_drain();
        repeat (3) @(negedge clk);
        chk("post_rst_retired", 32'(retired), 32'(1));
        chk("post_rst_flags", 32'({flag_n, flag_z, flag_c}), 32'(3'b000));
        chk("post_rst_empty", 32'(bus.out_valid), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
